// File: rtl/sad_accum_select.sv
// -----------------------------------------------------------------------------
// sad_accum_select
//
// Accumulates ROWS rows of 5x5 SAD values, one value per candidate
// (25 candidates). Each row arrives as five 60-bit words. After the last row
// the 25 sums are scanned in index order and the smallest is reported. On a
// tie the lowest index wins.
//
// Candidate numbering: idx = r*5 + c
//   r (row word)  : UH=0, UQ=1, M=2, LQ=3, LH=4
//   c (12b field) : h=0 [11:0], q=1 [23:12], f=2 [35:24], r=3 [47:36], i=4 [59:48]
//   mv_y = r-2, mv_x = c-2, so the centre candidate (M/f, idx 12) has mv (0,0).
//
// Parameters
//   ROWS   rows accumulated per block (1..8)
//   ACC_W  accumulator width
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   clear      synchronous abort of the block in progress
//   in_valid   row handshake valid; in_ready is 1 in IDLE/ACCUM
//   in_ready   row handshake ready
//   sad_UH..LH row SAD words, 5 x 12-bit fields each
//   out_valid  result handshake valid; held until out_ready
//   out_ready  result handshake ready
//   best_sad   minimum accumulated SAD
//   best_idx   index of the winning candidate
//   mv_x/mv_y  signed quarter-pel offset of the winner (decoded from best_idx)
// -----------------------------------------------------------------------------
module sad_accum_select #(
   parameter int ROWS  = 6,
   parameter int ACC_W = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [59:0]             sad_UH,
   input  logic [59:0]             sad_UQ,
   input  logic [59:0]             sad_M,
   input  logic [59:0]             sad_LQ,
   input  logic [59:0]             sad_LH,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        best_sad,
   output logic [4:0]              best_idx,
   output logic signed [2:0]       mv_x,
   output logic signed [2:0]       mv_y
);

   localparam int NCAND = 25;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      SEARCH = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state_reg;
   logic [2:0]         row_cnt_reg;   // rows accepted so far in this block
   logic [4:0]         scan_reg;      // candidate examined this SEARCH cycle
   logic [ACC_W-1:0]   acc_reg [NCAND];
   logic [ACC_W-1:0]   best_sad_reg;
   logic [4:0]         best_idx_reg;
   logic               out_valid_reg;

   logic [59:0]        row_words [5];
   logic [ACC_W-1:0]   field_ext [NCAND];
   logic               row_accept;
   logic               first_row;
   logic [ACC_W-1:0]   cand_sad;

   assign row_words[0] = sad_UH;
   assign row_words[1] = sad_UQ;
   assign row_words[2] = sad_M;
   assign row_words[3] = sad_LQ;
   assign row_words[4] = sad_LH;

   // Zero-extended 12-bit field for each candidate.
   genvar gi;
   generate
      for (gi = 0; gi < NCAND; gi++) begin : g_field
         assign field_ext[gi] = ACC_W'(row_words[gi / 5][(gi % 5) * 12 +: 12]);
      end
   endgenerate

   assign in_ready   = (state_reg == IDLE) || (state_reg == ACCUM);
   // clear wins over a simultaneous row, so the row is never counted.
   assign row_accept = in_valid && in_ready && !clear;
   // Only IDLE can hold the first row of a block: every exit back to IDLE
   // (reset, clear, result taken) starts a fresh block.
   assign first_row  = (state_reg == IDLE);
   assign cand_sad   = acc_reg[scan_reg];

   // Accumulator bank: load on the first row, add on later rows.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCAND; i++) acc_reg[i] <= '0;
      end else if (row_accept) begin
         for (int i = 0; i < NCAND; i++) begin
            acc_reg[i] <= first_row ? field_ext[i] : acc_reg[i] + field_ext[i];
         end
      end
   end

   // Control FSM with registered result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         row_cnt_reg   <= '0;
         scan_reg      <= '0;
         best_sad_reg  <= '0;
         best_idx_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else if (clear) begin
         state_reg     <= IDLE;
         row_cnt_reg   <= '0;
         scan_reg      <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, ACCUM: begin
               if (row_accept) begin
                  if (row_cnt_reg == 3'(ROWS - 1)) begin
                     state_reg   <= SEARCH;
                     row_cnt_reg <= '0;
                     scan_reg    <= '0;
                  end else begin
                     state_reg   <= ACCUM;
                     row_cnt_reg <= row_cnt_reg + 3'd1;
                  end
               end
            end
            SEARCH: begin
               // Strict less-than keeps the earliest index on ties.
               if (scan_reg == 5'd0 || cand_sad < best_sad_reg) begin
                  best_sad_reg <= cand_sad;
                  best_idx_reg <= scan_reg;
               end
               if (scan_reg == 5'(NCAND - 1)) begin
                  state_reg     <= DONE;
                  scan_reg      <= '0;
                  out_valid_reg <= 1'b1;
               end else begin
                  scan_reg <= scan_reg + 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign best_sad  = best_sad_reg;
   assign best_idx  = best_idx_reg;

   // Split best_idx into row/column without a divider (idx <= 24).
   logic [2:0] win_row;
   logic [4:0] win_col;

   always_comb begin
      win_row = 3'd0;
      if (best_idx_reg >= 5'd20)      win_row = 3'd4;
      else if (best_idx_reg >= 5'd15) win_row = 3'd3;
      else if (best_idx_reg >= 5'd10) win_row = 3'd2;
      else if (best_idx_reg >= 5'd5)  win_row = 3'd1;
      win_col = best_idx_reg - 5'(win_row) * 5'd5;
   end

   // Modulo-8 subtraction yields the two's-complement offset directly.
   assign mv_y = win_row - 3'd2;
   assign mv_x = win_col[2:0] - 3'd2;

endmodule

// File: tb/tb_sad_accum_select.sv
// -----------------------------------------------------------------------------
// tb_sad_accum_select
//
// Self-checking bench for sad_accum_select. Blocks of rows are held in an
// integer array. A reference model sums each candidate over the rows and picks
// the lowest sum (first index on ties). Directed scenarios cover centre win,
// all-equal tie, max value, backpressure, abort, and mid-block reset.
// Randomized blocks with random gaps and random tie-heavy data follow.
// -----------------------------------------------------------------------------
module tb_sad_accum_select;

   localparam int ROWS  = 6;
   localparam int ACC_W = 14;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  clear;
   logic                  in_valid;
   logic                  in_ready;
   logic [59:0]           sad_UH, sad_UQ, sad_M, sad_LQ, sad_LH;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_W-1:0]      best_sad;
   logic [4:0]            best_idx;
   logic signed [2:0]     mv_x, mv_y;

   int checks   = 0;
   int failures = 0;

   // blk[row][r][c] : field value of candidate r*5+c in that row
   int blk [ROWS][5][5];

   sad_accum_select #(.ROWS(ROWS), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sad_UH    (sad_UH),
      .sad_UQ    (sad_UQ),
      .sad_M     (sad_M),
      .sad_LQ    (sad_LQ),
      .sad_LH    (sad_LH),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .best_sad  (best_sad),
      .best_idx  (best_idx),
      .mv_x      (mv_x),
      .mv_y      (mv_y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one row of blk onto the five SAD words.
   task automatic drive_row(input int r);
      logic [59:0] w [5];
      for (int ri = 0; ri < 5; ri++) begin
         w[ri] = '0;
         for (int ci = 0; ci < 5; ci++) w[ri][ci*12 +: 12] = 12'(blk[r][ri][ci]);
      end
      sad_UH = w[0]; sad_UQ = w[1]; sad_M = w[2]; sad_LQ = w[3]; sad_LH = w[4];
   endtask

   task automatic drive_junk();
      sad_UH = {$urandom, $urandom}; sad_UQ = {$urandom, $urandom};
      sad_M  = {$urandom, $urandom}; sad_LQ = {$urandom, $urandom};
      sad_LH = {$urandom, $urandom};
   endtask

   // Present row r until accepted (in_ready high at the edge), bounded.
   task automatic send_row(input int r);
      bit rdy;
      int n;
      drive_row(r);
      in_valid = 1'b1;
      n = 0;
      do begin
         rdy = in_ready;
         tick();
         n++;
      end while (!rdy && n < 200);
      if (!rdy) check("row_accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   // Reference: per-candidate sums, minimum with lowest index on ties.
   task automatic model(output int bsad, output int bidx);
      int s;
      bsad = -1;
      bidx = 0;
      for (int idx = 0; idx < 25; idx++) begin
         s = 0;
         for (int r = 0; r < ROWS; r++) s += blk[r][idx / 5][idx % 5];
         if (bsad < 0 || s < bsad) begin
            bsad = s;
            bidx = idx;
         end
      end
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < ROWS; r++)
         for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5; b++) blk[r][a][b] = v;
   endtask

   task automatic fill_random(input int maxv);
      for (int r = 0; r < ROWS; r++)
         for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5; b++) blk[r][a][b] = int'($urandom_range(0, maxv));
   endtask

   // Send a full block, time the result, check it, hold it for `hold`
   // cycles (optionally with in_valid asserted), then take it.
   task automatic run_block(input string name, input int hold, input bit busy_in, input bit gaps);
      int esad, eidx, lat;
      model(esad, eidx);
      for (int r = 0; r < ROWS; r++) begin
         if (gaps) begin
            int g = int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++) begin
               drive_junk();
               tick();
            end
         end
         send_row(r);
      end
      lat = 0;
      while (!out_valid && lat < 100) begin
         check({name, "_in_ready_busy"}, int'(in_ready), 0);
         tick();
         lat++;
      end
      check({name, "_latency"}, lat, 25);
      check({name, "_best_sad"}, int'(best_sad), esad);
      check({name, "_best_idx"}, int'(best_idx), eidx);
      check({name, "_mv_x"}, int'(mv_x), (eidx % 5) - 2);
      check({name, "_mv_y"}, int'(mv_y), (eidx / 5) - 2);
      $display("%s: best_sad=%0d best_idx=%0d mv=(%0d,%0d) latency=%0d",
               name, best_sad, best_idx, mv_x, mv_y, lat);
      for (int k = 0; k < hold; k++) begin
         in_valid = busy_in;
         drive_junk();
         tick();
         check({name, "_hold_valid"}, int'(out_valid), 1);
         check({name, "_hold_ready"}, int'(in_ready), 0);
         check({name, "_hold_sad"}, int'(best_sad), esad);
         check({name, "_hold_idx"}, int'(best_idx), eidx);
      end
      in_valid  = busy_in;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({name, "_release_valid"}, int'(out_valid), 0);
      check({name, "_release_ready"}, int'(in_ready), 1);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_in_ready"}, int'(in_ready), 1);
      check({name, "_out_valid"}, int'(out_valid), 0);
      check({name, "_best_sad"}, int'(best_sad), 0);
      check({name, "_best_idx"}, int'(best_idx), 0);
      check({name, "_mv_x"}, int'(mv_x), -2);
      check({name, "_mv_y"}, int'(mv_y), -2);
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive_junk();
      repeat (3) tick();
      check_reset_values("reset");
      rst_n = 1'b1;
      tick();

      // Centre candidate wins.
      fill_const(10);
      for (int r = 0; r < ROWS; r++) blk[r][2][2] = 2;
      run_block("centre", 0, 1'b0, 1'b0);

      // All equal: index 0 wins the tie.
      fill_const(100);
      run_block("tie", 0, 1'b0, 1'b0);

      // Maximum values, last candidate wins by one.
      fill_const(1530);
      blk[2][4][4] = 1529;
      run_block("maxval", 0, 1'b0, 1'b0);

      // Backpressure with rows offered while the result is held.
      fill_random(1530);
      run_block("backpressure", 10, 1'b1, 1'b0);

      // Abort after 3 rows; a row offered together with clear is discarded.
      fill_random(1530);
      for (int r = 0; r < 3; r++) send_row(r);
      drive_junk();
      in_valid = 1'b1;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      fill_random(1530);
      run_block("after_abort", 2, 1'b0, 1'b1);

      // Reset in the middle of SEARCH.
      fill_random(1530);
      for (int r = 0; r < ROWS; r++) send_row(r);
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      check_reset_values("midreset");
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (out_valid) seen++;
      end
      check("midreset_no_valid", seen, 0);
      fill_random(1530);
      run_block("after_reset", 1, 1'b1, 1'b0);

      // Randomized blocks; small ranges make ties common.
      for (int b = 0; b < 8; b++) begin
         fill_random((b % 2 == 0) ? 3 : 1530);
         run_block($sformatf("rand%0d", b), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sad_accum_select.md
SAD_ACCUM_SELECT -- requirements
Module: sad_accum_select

Interface
REQ-001 The module SHALL have parameter ROWS, default 6, giving the number of SAD rows accumulated per block (legal range 1..8).
REQ-002 The module SHALL have parameter ACC_W, default 14, giving the accumulator width in bits; 6*6*255 = 9180 fits without overflow.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port clear, input, 1 bit: synchronous abort of the block in progress.
REQ-006 Port in_valid, input, 1 bit: the five sad_* words carry one row.
REQ-007 Port in_ready, output, 1 bit: the block can accept a row.
REQ-008 Ports sad_UH, sad_UQ, sad_M, sad_LQ and sad_LH, each input, 60 bits: row SADs from compute_sad.
- Field layout, 12 bits each: [11:0]=h, [23:12]=q, [35:24]=f, [47:36]=r, [59:48]=i.
REQ-009 Port out_valid, output, 1 bit: a best-match result is presented.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port best_sad, output, ACC_W bits: the minimum accumulated SAD.
REQ-012 Port best_idx, output, 5 bits: winning candidate index, row*5+col.
REQ-013 Ports mv_x and mv_y, outputs, 3 bits each, signed: quarter-pel offset of the winner.

Function
REQ-014 Candidates SHALL be numbered idx = r*5 + c, giving 25 candidates (0..24).
- Row r: UH=0, UQ=1, M=2, LQ=3, LH=4.
- Column c: h=0, q=1, f=2, r=3, i=4.
REQ-015 mv_y SHALL equal r-2 and mv_x SHALL equal c-2, so the centre candidate M/f is idx 12 with mv (0,0).
REQ-016 The FSM SHALL have four states, IDLE, ACCUM, SEARCH and DONE, with these transitions:
- IDLE -> ACCUM on the first accepted row;
- ACCUM -> SEARCH on acceptance of row ROWS;
- SEARCH -> DONE after 25 compare cycles;
- DONE -> IDLE on out_valid & out_ready.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in SEARCH and DONE; a row is accepted only when in_valid & in_ready.
REQ-018 On the first accepted row of a block, each of the 25 accumulators SHALL load its zero-extended 12-bit field; on later rows it SHALL add the field.
REQ-019 A 3-bit row counter SHALL count accepted rows; acceptance of row ROWS SHALL enter SEARCH with the scan index at 0 and the counter cleared.
REQ-020 In SEARCH, one candidate SHALL be examined per cycle, idx 0 through 24 in order.
- idx 0 loads best_sad/best_idx unconditionally.
- Each later idx replaces them only if acc[idx] < best_sad (strict less-than); on a tie the lowest idx wins.
REQ-021 out_valid SHALL rise 25 clock edges after the edge that accepts row ROWS and hold with stable outputs until out_ready is sampled high.
REQ-022 mv_x and mv_y SHALL be combinational decodes of the registered best_idx.
REQ-023 A cycle with out_valid & out_ready SHALL return the FSM to IDLE and deassert out_valid on the next edge; no new row is accepted in that same cycle.
REQ-024 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-025 clear=1 SHALL, on the next edge, return the FSM to IDLE from any state and zero the row counter and out_valid.
- clear has priority over a simultaneous row acceptance or output handshake; that row or result is discarded.
REQ-026 Accumulators SHALL not saturate; with the legal parameter range they do not overflow.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all internal state.
- State cleared: row counter, scan index, accumulators, best_sad and best_idx all 0.
- Resulting outputs: in_ready=1, out_valid=0, best_sad=0, best_idx=0, mv_x=mv_y=-2.
REQ-028 Reset asserted mid-block (in ACCUM, SEARCH or DONE) SHALL discard all progress; the next accepted row SHALL be treated as row 1.

Verification
REQ-029 Scenario, normal block: 6 rows with every field 10 except sad_M f-field 2 -> best_sad=12, best_idx=12, mv=(0,0), out_valid 25 edges after the 6th accept.
REQ-030 Scenario, all-equal tie: 6 rows with all fields 100 -> best_sad=600, best_idx=0, mv_x=-2, mv_y=-2.
REQ-031 Scenario, maximum value: all fields 1530 for 6 rows except sad_LH i-field 1529 in row 3 -> best_sad=9179, best_idx=24, mv=(+2,+2), no overflow.
REQ-032 Scenario, backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> outputs stable, in_ready=0, no row accepted; releasing out_ready returns to IDLE.
REQ-033 Scenario, abort: clear after 3 rows, then a fresh 6-row block -> the result reflects only the fresh block.
REQ-034 Scenario, mid-block reset: reset mid-SEARCH -> out_valid never rises for that block and all reset values are observed.
